// File: rtl/uart_pkg.sv
// Shared UART types and constants for the transmit and receive paths.
package uart_pkg;

    // Transmit frame sequencing states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Encodings for the PARITY_ODD parameter.
    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Host-side byte handshake plus serial line and status of the UART transmitter.
interface uart_tx_ctrl_if #(
    parameter int DATA_BITS = 8
);
    logic                 tx_valid;
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_ready;
    logic                 tx;
    logic                 busy;
    logic                 done;

    // Byte source side.
    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready,
        input  tx,
        input  busy,
        input  done
    );

    // Transmitter side.
    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready,
        output tx,
        output busy,
        output done
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-time counter: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
// Held at zero while clear is high so every bit period starts from a known phase.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    output logic tick
);
    localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] count_reg;

    // Free-running bit-time count, wrapping at the terminal value.
    always_ff @(posedge clk) begin
        if (!nrst || clear) begin
            count_reg <= '0;
        end else if (count_reg == CNT_LAST) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_reg + CNT_W'(1);
        end
    end

    assign tick = (count_reg == CNT_LAST);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: takes one byte per handshake and serialises it
// LSB-first as start, data, optional parity and stop bits on a registered tx line.
module uart_tx_ctrl
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic           clk,
    input  logic           nrst,
    uart_tx_ctrl_if.slave  bus
);
    // The counter serves both the data bits and the stop bits.
    localparam int                    BIT_CNT_W = $clog2(DATA_BITS);
    localparam logic [BIT_CNT_W-1:0]  DATA_LAST = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0]  STOP_LAST = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic                  ODD_SEL   = (PARITY_ODD != 0);
    localparam logic                  USE_PAR   = (PARITY_EN != 0);

    tx_state_t              state_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   parity_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt_reg;
    logic                   tx_reg;
    logic                   done_reg;
    logic                   bit_tick;
    logic                   baud_clear;

    // The baud counter idles at zero, so START always gets a full bit time;
    // later state changes happen on bit_tick where the counter wraps anyway.
    assign baud_clear = (state_reg == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .nrst  (nrst),
        .clear (baud_clear),
        .tick  (bit_tick)
    );

    // Frame FSM; tx is set one edge ahead so it changes exactly at bit boundaries.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_reg   <= IDLE;
            shift_reg   <= '0;
            parity_reg  <= 1'b0;
            bit_cnt_reg <= '0;
            tx_reg      <= 1'b1;
            done_reg    <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    tx_reg <= 1'b1;
                    if (bus.tx_valid) begin
                        shift_reg   <= bus.tx_data;
                        parity_reg  <= (^bus.tx_data) ^ ODD_SEL;
                        bit_cnt_reg <= '0;
                        tx_reg      <= 1'b0;
                        state_reg   <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_reg      <= shift_reg[0];
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt_reg == DATA_LAST) begin
                            bit_cnt_reg <= '0;
                            if (USE_PAR) begin
                                tx_reg    <= parity_reg;
                                state_reg <= PARITY;
                            end else begin
                                tx_reg    <= 1'b1;
                                state_reg <= STOP;
                            end
                        end else begin
                            shift_reg   <= shift_reg >> 1;
                            tx_reg      <= shift_reg[1];
                            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        tx_reg      <= 1'b1;
                        bit_cnt_reg <= '0;
                        state_reg   <= STOP;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        if (bit_cnt_reg == STOP_LAST) begin
                            bit_cnt_reg <= '0;
                            done_reg    <= 1'b1;
                            state_reg   <= IDLE;
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + BIT_CNT_W'(1);
                        end
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.tx_ready = (state_reg == IDLE);
    assign bus.busy     = (state_reg != IDLE);
    assign bus.tx       = tx_reg;
    assign bus.done     = done_reg;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances with different frame formats
// share one clock; each test drives one instance and checks tx cycle by cycle.
module tb_uart_tx_ctrl;
    localparam int CPB = 4;
    // Instance 0: plain 8N1, 1: even parity, 2: odd parity, 3: two stop bits.
    localparam int P_PAR_EN [4] = '{0, 1, 1, 0};
    localparam int P_PAR_ODD[4] = '{uart_pkg::PARITY_EVEN, uart_pkg::PARITY_EVEN,
                                    uart_pkg::PARITY_ODD,  uart_pkg::PARITY_EVEN};
    localparam int P_STOP   [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic [3:0] nrst;
    logic [3:0] valid;
    logic [7:0] data [4];
    logic [3:0] tx_w, ready_w, busy_w, done_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dut
        uart_tx_ctrl_if #(.DATA_BITS(8)) bus ();
        assign bus.tx_valid = valid[gi];
        assign bus.tx_data  = data[gi];
        assign tx_w[gi]     = bus.tx;
        assign ready_w[gi]  = bus.tx_ready;
        assign busy_w[gi]   = bus.busy;
        assign done_w[gi]   = bus.done;

        uart_tx_ctrl #(
            .CLKS_PER_BIT (CPB),
            .DATA_BITS    (8),
            .PARITY_EN    (P_PAR_EN[gi]),
            .PARITY_ODD   (P_PAR_ODD[gi]),
            .STOP_BITS    (P_STOP[gi])
        ) u_dut (
            .clk  (clk),
            .nrst (nrst[gi]),
            .bus  (bus)
        );
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait until instance k is ready to accept a byte.
    task automatic wait_ready(input int k, input string name);
        int n;
        n = 0;
        while (ready_w[k] !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        vectors++;
        if (ready_w[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s wait_ready: tx_ready=%b after %0d cycles, required 1", name, ready_w[k], n);
        end
    endtask

    // Called in cycle N+1; checks every frame cycle and ends in cycle N+F+1.
    // bits[i] is the i-th serial bit on the line.
    task automatic expect_frame(input int k, input logic [11:0] bits, input int nb,
                                input bit disturb, input string name);
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < CPB; c++) begin
                vectors++;
                if (tx_w[k] !== bits[b] || ready_w[k] !== 1'b0 || busy_w[k] !== 1'b1 || done_w[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL %s bit%0d cyc%0d: tx=%b ready=%b busy=%b done=%b, required tx=%b ready=0 busy=1 done=0",
                             name, b, c, tx_w[k], ready_w[k], busy_w[k], done_w[k], bits[b]);
                end
                if (disturb) begin
                    valid[k] = (c % 2 == 0);
                    data[k]  = ~data[k];
                end
                step();
            end
        end
        if (disturb) valid[k] = 1'b0;
        vectors++;
        if (done_w[k] !== 1'b1 || tx_w[k] !== 1'b1 || ready_w[k] !== 1'b1 || busy_w[k] !== 1'b0) begin
            miscompares++;
            $display("FAIL %s end: done=%b tx=%b ready=%b busy=%b, required done=1 tx=1 ready=1 busy=0",
                     name, done_w[k], tx_w[k], ready_w[k], busy_w[k]);
        end
        $display("frame %s: %0d serial bits checked on instance %0d", name, nb, k);
    endtask

    // Single handshake, full frame check, then done must drop.
    task automatic send(input int k, input logic [7:0] byte_v, input logic [11:0] bits,
                        input int nb, input bit disturb, input string name);
        wait_ready(k, name);
        valid[k] = 1'b1;
        data[k]  = byte_v;
        step();
        valid[k] = 1'b0;
        data[k]  = ~byte_v;
        expect_frame(k, bits, nb, disturb, name);
        step();
        vectors++;
        if (done_w[k] !== 1'b0 || tx_w[k] !== 1'b1) begin
            miscompares++;
            $display("FAIL %s after: done=%b tx=%b, required done=0 tx=1", name, done_w[k], tx_w[k]);
        end
    endtask

    task automatic test_reset();
        nrst     = 4'b0000;
        valid[0] = 1'b1;
        data[0]  = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if (tx_w[0] !== 1'b1 || ready_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || done_w[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset cyc%0d: tx=%b ready=%b busy=%b done=%b, required tx=1 ready=1 busy=0 done=0",
                         i, tx_w[0], ready_w[0], busy_w[0], done_w[0]);
            end
        end
        valid[0] = 1'b0;
        nrst     = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            vectors++;
            if (tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL post_reset cyc%0d: tx=%b busy=%b, required tx=1 busy=0", i, tx_w[0], busy_w[0]);
            end
        end
        $display("reset: instance 0 held idle through reset and release");
    endtask

    task automatic test_frame_a5();
        send(0, 8'hA5, 12'(10'b1101001010), 10, 1'b0, "a5");
    endtask

    task automatic test_parity();
        send(1, 8'h07, 12'(11'b11000001110), 11, 1'b0, "par_even_07");
        send(2, 8'h07, 12'(11'b10000001110), 11, 1'b0, "par_odd_07");
    endtask

    task automatic test_back_to_back();
        wait_ready(0, "b2b");
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        step();
        expect_frame(0, 12'(10'b1000000000), 10, 1'b0, "b2b_00");
        data[0] = 8'hFF;
        step();
        expect_frame(0, 12'(10'b1111111110), 10, 1'b0, "b2b_ff");
        valid[0] = 1'b0;
        step();
        vectors++;
        if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1 || busy_w[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b tail: done=%b tx=%b busy=%b, required done=0 tx=1 busy=0", done_w[0], tx_w[0], busy_w[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        bit bad;
        wait_ready(0, "mid_rst");
        valid[0] = 1'b1;
        data[0]  = 8'h00;
        step();
        valid[0] = 1'b0;
        // Cycle N+1 now; move into the middle of data bit 3 (cycles N+17..N+20).
        repeat (17) step();
        vectors++;
        if (tx_w[0] !== 1'b0 || busy_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst pre: tx=%b busy=%b, required tx=0 busy=1", tx_w[0], busy_w[0]);
        end
        nrst[0] = 1'b0;
        step();
        nrst[0] = 1'b1;
        vectors++;
        if (tx_w[0] !== 1'b1 || done_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || ready_w[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_rst abort: tx=%b done=%b busy=%b ready=%b, required tx=1 done=0 busy=0 ready=1",
                     tx_w[0], done_w[0], busy_w[0], ready_w[0]);
        end
        bad = 1'b0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (done_w[0] !== 1'b0 || tx_w[0] !== 1'b1) bad = 1'b1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL mid_rst quiet: done or tx moved after abort, required done=0 tx=1 for 50 cycles");
        end
        send(0, 8'h3C, 12'(10'b1001111000), 10, 1'b0, "after_rst_3c");
    endtask

    task automatic test_stop2_ignore();
        send(3, 8'h96, 12'(11'b11100101100), 11, 1'b1, "stop2_96");
    endtask

    initial begin
        nrst  = 4'b0000;
        valid = 4'b0000;
        for (int i = 0; i < 4; i++) data[i] = 8'h00;
        test_reset();
        test_frame_a5();
        test_parity();
        test_back_to_back();
        test_reset_mid_frame();
        test_stop2_ignore();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
